// File: rtl/approx_mul_seq_pkg.sv
// Shared types and helpers for the sequential approximate shift-add multiplier.
package approx_mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Partial product for step idx: A shifted by idx when the multiplier bit is set,
  // with the low trunc columns cleared in approximate mode. Caller narrows the result.
  function automatic logic [63:0] masked_term(
    input logic [31:0] a,
    input logic        b_bit,
    input logic [31:0] idx,
    input logic        approx,
    input logic [31:0] trunc
  );
    logic [63:0] term;
    logic [63:0] mask;
    term = b_bit ? ({32'd0, a} << idx) : '0;
    mask = approx ? ((64'd1 << trunc) - 64'd1) : '0;
    return term & ~mask;
  endfunction

endpackage

// File: rtl/approx_mul_seq_pp_term.sv
// Combinational masked partial-product generator for one shift-add step.
module approx_pp_term
  import approx_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [CW-1:0]      idx,
  input  logic               approx_en,
  output logic [2*WIDTH-1:0] term
);

  always_comb begin
    term = (2*WIDTH)'(masked_term(32'(a), b_bit, 32'(idx), approx_en, 32'(TRUNC)));
  end

endmodule

// File: rtl/approx_mul_seq.sv
// Sequential shift-add multiplier, one partial product per cycle, with optional
// truncation of the low product columns. Valid/ready handshake on both sides.
module approx_mul_seq
  import approx_mul_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TRUNC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 approx_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*WIDTH-1:0]   O,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 apx_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   term;

  approx_pp_term #(
    .WIDTH (WIDTH),
    .TRUNC (TRUNC),
    .CW    (CW)
  ) u_pp (
    .a         (a_q),
    .b_bit     (b_q[cnt_q]),
    .idx       (cnt_q),
    .approx_en (apx_q),
    .term      (term)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      apx_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            apx_q <= approx_en;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          acc_q <= acc_q + term;
          // Counter parks at zero after the last step so non-power-of-two widths stay in range.
          cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign O = acc_q;

endmodule

// File: doc/approx_mul_seq.md
APPROX_MUL_SEQ -- requirements
Module: approx_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 SHALL have parameter TRUNC, default 4, number of least-significant product columns dropped in approximate mode; legal range 0..WIDTH.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port A, input, WIDTH bits, unsigned multiplicand.
REQ-006 SHALL have port B, input, WIDTH bits, unsigned multiplier.
REQ-007 SHALL have port approx_en, input, 1 bit, selects approximate (1) or exact (0) mode; sampled with the operands.
REQ-008 SHALL have port in_valid, input, 1 bit, operands and approx_en are valid.
REQ-009 SHALL have port in_ready, output, 1 bit, block accepts new operands.
REQ-010 SHALL have port O, output, 2*WIDTH bits, product.
REQ-011 SHALL have port out_valid, output, 1 bit, O holds a completed result.
REQ-012 SHALL have port out_ready, input, 1 bit, consumer accepts O.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-015 SHALL accept operands on an edge where in_ready and in_valid are both 1: register A, B and approx_en, clear the accumulator and step counter, then go IDLE->RUN.
REQ-016 SHALL ignore A, B, approx_en and in_valid outside the accept edge.
REQ-017 SHALL, in RUN at step i (0..WIDTH-1), add term T_i = B[i] ? (A << i) : 0, zero-extended to 2*WIDTH bits, to the accumulator.
REQ-018 SHALL, when the registered approx_en is 1, clear bits [TRUNC-1:0] of T_i before the add; no compensation constant is added.
REQ-019 SHALL, when the registered approx_en is 0 or TRUNC=0, produce the exact product A*B.
REQ-020 SHALL keep the accumulator at 2*WIDTH bits; the sum never overflows, so no saturation or wrap logic is required.
REQ-021 SHALL go RUN->DONE on the edge completing step WIDTH-1, so out_valid rises exactly WIDTH cycles after the accept edge.
REQ-022 SHALL drive O from the accumulator and hold O and out_valid stable in DONE while out_ready is 0, for any number of cycles.
REQ-023 SHALL go DONE->IDLE on an edge where out_ready is 1; in_ready rises the following cycle, with no same-cycle accept/retire overlap.
REQ-024 SHALL treat out_ready as don't-care outside DONE.
REQ-025 SHALL produce O=0 for A=0 or B=0 in either mode, taking the full WIDTH cycles.

Reset
REQ-026 SHALL, on rst=1 at a rising edge, enter IDLE, clear the accumulator, counter and registered operands, and drive O=0, out_valid=0 and in_ready=1 on the next cycle.
REQ-027 SHALL let rst take priority over every other input, including mid-RUN and in DONE; an in-flight result is discarded and no out_valid pulse follows.

Structure
REQ-028 SHALL place the FSM state enumeration (IDLE, RUN, DONE) in the shared multiplier package together with a function computing the masked term of REQ-017/018.
REQ-029 SHALL contain one sub-module, approx_pp_term, combinational, generating the masked shifted partial product T_i from A, B[i], i, approx_en and TRUNC.
REQ-030 SHALL size the step counter as clog2(WIDTH) bits.

Verification
REQ-031 SHALL cover: WIDTH=8, TRUNC=4, A=255, B=255, approx_en=0 -> O=65025, out_valid 8 cycles after accept.
REQ-032 SHALL cover: same operands, approx_en=1 -> O=64976.
REQ-033 SHALL cover: A=3, B=5, approx_en=1, TRUNC=4 -> O=0; with approx_en=0 -> O=15.
REQ-034 SHALL cover: out_ready held 0 for 5 cycles in DONE -> O and out_valid stable, in_ready 0; out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-035 SHALL cover: rst asserted at RUN step 3 -> next cycle IDLE, O=0, out_valid=0; a new accept then yields the correct product.
REQ-036 SHALL cover: randomized back-to-back transactions for WIDTH in {4,8,16} and TRUNC in {0, WIDTH/2, WIDTH} -> every O matches the package reference function.
